// File: rtl/m68k_bus_sequencer.sv
// m68k_bus_sequencer
// Runs one 68000 bus transfer (byte, word or longword as two word cycles,
// or a 6800-style VPA/E-clock cycle) for a latched request from the Pi
// register interface. All bus-facing outputs are registered and advance
// only on the one-cycle CLK_7M edge strobes.

module m68k_bus_sequencer #(
    parameter int TIMEOUT_MC = 1024
) (
    input  logic        i_sys_clk,
    input  logic        i_reset,
    input  logic        i_mc_clk_rising,
    input  logic        i_mc_clk_falling,
    input  logic        i_start,
    input  logic [23:0] i_req_address,
    input  logic [2:0]  i_req_fc,
    input  logic        i_req_rw,
    input  logic [1:0]  i_req_size,
    input  logic [31:0] i_req_data_write,
    input  logic        i_dtack_n,
    input  logic        i_berr_n,
    input  logic        i_vpa_n,
    input  logic        i_eclk,
    output logic [22:0] o_a_out,
    output logic [15:0] o_d_out,
    input  logic [15:0] i_d_in,
    output logic [2:0]  o_fc_out,
    output logic        o_rnw_out,
    output logic        o_as_n,
    output logic        o_uds_n,
    output logic        o_lds_n,
    output logic        o_vma_n,
    output logic        o_abus_oe,
    output logic        o_dbus_oe,
    output logic        o_ctrl_oe,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_terminated_normally,
    output logic [31:0] o_data_read
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_LONG = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    // Counter wide enough to reach TIMEOUT_MC; a 1-bit stub when disabled.
    localparam int CNT_W = (TIMEOUT_MC > 1) ? $clog2(TIMEOUT_MC + 1) : 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_WAIT,
        ST_VPA,
        ST_S6,
        ST_S7,
        ST_FIN
    } state_t;

    state_t             r_state;
    logic [23:0]        r_addr;
    logic [2:0]         r_fc;
    logic               r_rw;
    logic [1:0]         r_size;
    logic [31:0]        r_wdata;
    logic               r_second;
    logic               r_err;
    logic               r_vma_on;
    logic               r_eclk_d;
    logic [CNT_W-1:0]   r_to_cnt;

    logic [22:0]        r_a_out;
    logic [15:0]        r_d_out;
    logic [2:0]         r_fc_out;
    logic               r_rnw;
    logic               r_as_n;
    logic               r_uds_n;
    logic               r_lds_n;
    logic               r_vma_n;
    logic               r_abus_oe;
    logic               r_dbus_oe;
    logic               r_ctrl_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_term_ok;
    logic [31:0]        r_rdata;

    logic               w_uds_en;
    logic               w_lds_en;
    logic [15:0]        w_wr_word;
    logic [31:0]        w_rd_data;
    logic               w_eclk_fall;
    logic [CNT_W-1:0]   w_to_next;
    logic               w_timeout;

    // Byte-lane selection, write word for the current cycle and merged read result.
    always_comb begin
        w_uds_en  = 1'b1;
        w_lds_en  = 1'b1;
        w_wr_word = r_wdata[15:0];
        w_rd_data = r_rdata;
        case (r_size)
            SZ_BYTE: begin
                w_uds_en  = ~r_addr[0];
                w_lds_en  = r_addr[0];
                w_wr_word = {r_wdata[7:0], r_wdata[7:0]};
                if (r_addr[0]) begin
                    w_rd_data = {24'h00_0000, i_d_in[7:0]};
                end else begin
                    w_rd_data = {24'h00_0000, i_d_in[15:8]};
                end
            end
            SZ_WORD: begin
                w_rd_data = {16'h0000, i_d_in};
            end
            SZ_LONG: begin
                if (r_second) begin
                    w_wr_word = r_wdata[15:0];
                    w_rd_data = {r_rdata[31:16], i_d_in};
                end else begin
                    w_wr_word = r_wdata[31:16];
                    w_rd_data = {i_d_in, 16'h0000};
                end
            end
            default: begin
                w_wr_word = r_wdata[15:0];
            end
        endcase
    end

    // E-clock falling-edge detect and wait-state timeout compare.
    always_comb begin
        w_eclk_fall = r_eclk_d & ~i_eclk;
        w_to_next   = r_to_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (TIMEOUT_MC != 0) begin
            w_timeout = (w_to_next == CNT_W'(TIMEOUT_MC));
        end else begin
            w_timeout = 1'b0;
        end
    end

    // Bus-cycle state machine with all bus and status outputs registered.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= 24'h00_0000;
            r_fc      <= 3'd0;
            r_rw      <= 1'b1;
            r_size    <= SZ_BYTE;
            r_wdata   <= 32'h0000_0000;
            r_second  <= 1'b0;
            r_err     <= 1'b0;
            r_vma_on  <= 1'b0;
            r_eclk_d  <= 1'b0;
            r_to_cnt  <= '0;
            r_a_out   <= 23'h00_0000;
            r_d_out   <= 16'h0000;
            r_fc_out  <= 3'd0;
            r_rnw     <= 1'b1;
            r_as_n    <= 1'b1;
            r_uds_n   <= 1'b1;
            r_lds_n   <= 1'b1;
            r_vma_n   <= 1'b1;
            r_abus_oe <= 1'b0;
            r_dbus_oe <= 1'b0;
            r_ctrl_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_term_ok <= 1'b0;
            r_rdata   <= 32'h0000_0000;
        end else begin
            r_eclk_d <= i_eclk;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_req_size == SZ_RSVD) begin
                            // Reserved size: complete at once with an error, bus untouched.
                            r_done    <= 1'b1;
                            r_term_ok <= 1'b0;
                        end else begin
                            r_addr   <= i_req_address;
                            r_fc     <= i_req_fc;
                            r_rw     <= i_req_rw;
                            r_size   <= i_req_size;
                            r_wdata  <= i_req_data_write;
                            r_second <= 1'b0;
                            r_err    <= 1'b0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_WAIT_S0;
                        end
                    end
                end
                ST_WAIT_S0: begin
                    if (i_mc_clk_falling) begin
                        r_a_out   <= r_addr[23:1];
                        r_fc_out  <= r_fc;
                        r_rnw     <= r_rw;
                        r_abus_oe <= 1'b1;
                        r_ctrl_oe <= 1'b1;
                        r_state   <= ST_S1;
                    end
                end
                ST_S1: begin
                    if (i_mc_clk_rising) begin
                        r_as_n <= 1'b0;
                        // Reads open the data strobes together with AS.
                        if (r_rw) begin
                            r_uds_n <= ~w_uds_en;
                            r_lds_n <= ~w_lds_en;
                        end
                        r_state <= ST_S2;
                    end
                end
                ST_S2: begin
                    if (i_mc_clk_falling) begin
                        // Writes put data on the bus, then strobe it half a clock after AS.
                        if (!r_rw) begin
                            r_d_out   <= w_wr_word;
                            r_dbus_oe <= 1'b1;
                            r_uds_n   <= ~w_uds_en;
                            r_lds_n   <= ~w_lds_en;
                        end
                        r_state <= ST_S3;
                    end
                end
                ST_S3: begin
                    if (i_mc_clk_rising) begin
                        r_to_cnt <= '0;
                        r_vma_on <= 1'b0;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_mc_clk_falling) begin
                        if (!i_berr_n) begin
                            r_as_n    <= 1'b1;
                            r_uds_n   <= 1'b1;
                            r_lds_n   <= 1'b1;
                            r_vma_n   <= 1'b1;
                            r_dbus_oe <= 1'b0;
                            r_err     <= 1'b1;
                            r_state   <= ST_FIN;
                        end else if (!i_dtack_n) begin
                            r_state <= ST_S6;
                        end else if (!i_vpa_n) begin
                            r_state <= ST_VPA;
                        end
                    end else if (i_mc_clk_rising) begin
                        r_to_cnt <= w_to_next;
                        if (w_timeout) begin
                            r_as_n    <= 1'b1;
                            r_uds_n   <= 1'b1;
                            r_lds_n   <= 1'b1;
                            r_vma_n   <= 1'b1;
                            r_dbus_oe <= 1'b0;
                            r_err     <= 1'b1;
                            r_state   <= ST_FIN;
                        end
                    end
                end
                ST_VPA: begin
                    // First E fall opens VMA, the next one closes the synchronous cycle.
                    if (w_eclk_fall) begin
                        if (r_vma_on) begin
                            r_state <= ST_S6;
                        end else begin
                            r_vma_n  <= 1'b0;
                            r_vma_on <= 1'b1;
                        end
                    end
                end
                ST_S6: begin
                    if (i_mc_clk_rising) begin
                        r_state <= ST_S7;
                    end
                end
                ST_S7: begin
                    if (i_mc_clk_falling) begin
                        if (r_rw) begin
                            r_rdata <= w_rd_data;
                        end
                        r_as_n    <= 1'b1;
                        r_uds_n   <= 1'b1;
                        r_lds_n   <= 1'b1;
                        r_vma_n   <= 1'b1;
                        r_dbus_oe <= 1'b0;
                        r_state   <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    r_abus_oe <= 1'b0;
                    r_ctrl_oe <= 1'b0;
                    r_rnw     <= 1'b1;
                    if (!r_err && (r_size == SZ_LONG) && !r_second) begin
                        // Second half of a longword: next word address, wraps at 24 bits.
                        r_second <= 1'b1;
                        r_addr   <= r_addr + 24'd2;
                        r_state  <= ST_WAIT_S0;
                    end else begin
                        r_done    <= 1'b1;
                        r_term_ok <= ~r_err;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_a_out               = r_a_out;
    assign o_d_out               = r_d_out;
    assign o_fc_out              = r_fc_out;
    assign o_rnw_out             = r_rnw;
    assign o_as_n                = r_as_n;
    assign o_uds_n               = r_uds_n;
    assign o_lds_n               = r_lds_n;
    assign o_vma_n               = r_vma_n;
    assign o_abus_oe             = r_abus_oe;
    assign o_dbus_oe             = r_dbus_oe;
    assign o_ctrl_oe             = r_ctrl_oe;
    assign o_busy                = r_busy;
    assign o_done                = r_done;
    assign o_terminated_normally = r_term_ok;
    assign o_data_read           = r_rdata;

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Directed bench for m68k_bus_sequencer: drives transfers against a small
// bus responder and compares observed strobe/data behaviour with
// hand-computed expectations.

module tb_m68k_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mc_rising = 1'b0;
    logic        mc_falling = 1'b0;
    logic        start = 1'b0;
    logic [23:0] req_address = 24'h0;
    logic [2:0]  req_fc = 3'd0;
    logic        req_rw = 1'b1;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_data_write = 32'h0;
    logic        dtack_n = 1'b1;
    logic        berr_n = 1'b1;
    logic        vpa_n = 1'b1;
    logic        eclk = 1'b0;
    logic [15:0] d_in = 16'h0;

    logic [22:0] a_out;
    logic [15:0] d_out;
    logic [2:0]  fc_out;
    logic        rnw_out, as_n, uds_n, lds_n, vma_n;
    logic        abus_oe, dbus_oe, ctrl_oe, busy, done, term_ok;
    logic [31:0] data_read;

    int chk_cnt = 0;
    int err_cnt = 0;

    m68k_bus_sequencer #(.TIMEOUT_MC(16)) dut (
        .i_sys_clk(clk), .i_reset(reset),
        .i_mc_clk_rising(mc_rising), .i_mc_clk_falling(mc_falling),
        .i_start(start), .i_req_address(req_address), .i_req_fc(req_fc),
        .i_req_rw(req_rw), .i_req_size(req_size), .i_req_data_write(req_data_write),
        .i_dtack_n(dtack_n), .i_berr_n(berr_n), .i_vpa_n(vpa_n), .i_eclk(eclk),
        .o_a_out(a_out), .o_d_out(d_out), .i_d_in(d_in), .o_fc_out(fc_out),
        .o_rnw_out(rnw_out), .o_as_n(as_n), .o_uds_n(uds_n), .o_lds_n(lds_n),
        .o_vma_n(vma_n), .o_abus_oe(abus_oe), .o_dbus_oe(dbus_oe), .o_ctrl_oe(ctrl_oe),
        .o_busy(busy), .o_done(done), .o_terminated_normally(term_ok),
        .o_data_read(data_read)
    );

    always #5 clk = ~clk;

    // MC clock: 8 sys_clk period (rise strobe at phase 0, fall at 4); E: 80 sys_clk, 48 low / 32 high.
    int ph = 7;
    int eph = 79;
    always @(negedge clk) begin
        ph  = (ph + 1) % 8;
        eph = (eph + 1) % 80;
        mc_rising  = (ph == 0);
        mc_falling = (ph == 4);
        eclk       = (eph >= 48);
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of the last transaction.
    int          r_as_cnt, r_first_fall, r_as_rise, r_oe_fall, r_lag, r_rises;
    logic [22:0] r_addr0, r_addr1;
    logic [2:0]  r_fc0;
    logic        r_rnw0, r_uds_seen, r_lds_seen, r_vma_seen, r_vma_efall;
    logic        r_ok, r_finished, r_done_after, r_busy_after, r_as_at_done;
    logic [15:0] r_dout;
    logic [31:0] r_data;

    // mode: 0 = DTACK, 1 = BERR and DTACK together, 2 = VPA, 3 = no response
    task automatic run_txn(input string tag, input logic [23:0] addr, input logic [2:0] fc,
                           input logic rw, input logic [1:0] size, input logic [31:0] wdata,
                           input int mode, input logic [15:0] rd0, input logic [15:0] rd1);
        logic prev_as, prev_oe, prev_vma, prev_e;
        r_as_cnt = 0; r_first_fall = -1; r_as_rise = -1; r_oe_fall = -2; r_lag = -1; r_rises = 0;
        r_addr0 = '0; r_addr1 = '1; r_fc0 = '0; r_rnw0 = 1'b1;
        r_uds_seen = 1'b0; r_lds_seen = 1'b0; r_vma_seen = 1'b0; r_vma_efall = 1'b0;
        r_ok = 1'b0; r_finished = 1'b0; r_dout = '0; r_data = '0; r_as_at_done = 1'b0;
        @(posedge clk); #1;
        req_address = addr; req_fc = fc; req_rw = rw; req_size = size;
        req_data_write = wdata; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        prev_as = as_n; prev_oe = dbus_oe; prev_vma = vma_n; prev_e = eclk;
        for (int cyc = 0; cyc < 3000 && !r_finished; cyc++) begin
            @(posedge clk); #1;
            if (!as_n && prev_as) begin
                r_as_cnt++;
                if (r_as_cnt == 1) begin
                    r_first_fall = cyc; r_addr0 = a_out; r_fc0 = fc_out; r_rnw0 = rnw_out;
                end else begin
                    r_addr1 = a_out;
                end
            end
            if (as_n && !prev_as) r_as_rise = cyc;
            if (!dbus_oe && prev_oe) r_oe_fall = cyc;
            if (dbus_oe) r_dout = d_out;
            if (!uds_n) r_uds_seen = 1'b1;
            if (!lds_n) r_lds_seen = 1'b1;
            if (r_as_cnt == 1 && r_lag < 0 && (!uds_n || !lds_n)) r_lag = cyc - r_first_fall;
            if (r_first_fall >= 0 && cyc > r_first_fall && mc_rising) r_rises++;
            if (!vma_n && prev_vma) begin
                r_vma_seen = 1'b1;
                r_vma_efall = prev_e && !eclk;
            end
            if (done) begin
                r_finished = 1'b1; r_ok = term_ok; r_data = data_read; r_as_at_done = as_n;
            end
            prev_as = as_n; prev_oe = dbus_oe; prev_vma = vma_n; prev_e = eclk;
            // Bus responder
            if (!as_n) begin
                d_in    = (r_as_cnt <= 1) ? rd0 : rd1;
                dtack_n = !(mode == 0 || mode == 1);
                berr_n  = !(mode == 1);
                vpa_n   = !(mode == 2);
            end else begin
                dtack_n = 1'b1; berr_n = 1'b1; vpa_n = 1'b1;
            end
        end
        if (!r_finished) check_value({tag, "_done_seen"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        r_done_after = done;
        r_busy_after = busy;
    endtask

    initial begin
        logic got;
        repeat (4) @(posedge clk);
        #1;
        check_value("rst_strobes", {27'd0, as_n, uds_n, lds_n, vma_n, rnw_out}, 32'h1F);
        check_value("rst_flags", {26'd0, abus_oe, dbus_oe, ctrl_oe, busy, done, term_ok}, 32'h0);
        check_value("rst_data", data_read, 32'h0);
        check_value("rst_addr", {a_out, fc_out}, 32'h0);
        check_value("rst_dout", d_out, 32'h0);
        reset = 1'b0;

        // Word read, DTACK on first sample
        run_txn("wrd", 24'hDFF006, 3'd5, 1'b1, 2'd1, 32'h0, 0, 16'hBEEF, 16'h0);
        check_value("wrd_addr", r_addr0, 23'h6FF803);
        check_value("wrd_fc", r_fc0, 3'd5);
        check_value("wrd_uds", r_uds_seen, 1'b1);
        check_value("wrd_lds", r_lds_seen, 1'b1);
        check_value("wrd_lag", r_lag, 0);
        check_value("wrd_ok", r_ok, 1'b1);
        check_value("wrd_data", r_data, 32'h0000BEEF);
        check_value("wrd_pulse", r_done_after, 1'b0);
        check_value("wrd_busy", r_busy_after, 1'b0);

        // Byte write 0x5A to an odd address
        run_txn("bwr", 24'hBFE001, 3'd5, 1'b0, 2'd0, 32'h0000005A, 0, 16'h0, 16'h0);
        check_value("bwr_uds", r_uds_seen, 1'b0);
        check_value("bwr_lds", r_lds_seen, 1'b1);
        check_value("bwr_dout", r_dout, 16'h5A5A);
        check_value("bwr_lag", r_lag, 4);
        check_value("bwr_oe_as", r_oe_fall, r_as_rise);
        check_value("bwr_rnw", r_rnw0, 1'b0);
        check_value("bwr_ok", r_ok, 1'b1);

        // Long read across the 24-bit wrap
        run_txn("lrd", 24'hFFFFFE, 3'd1, 1'b1, 2'd2, 32'h0, 0, 16'h1234, 16'h5678);
        check_value("lrd_addr0", r_addr0, 23'h7FFFFF);
        check_value("lrd_addr1", r_addr1, 23'h000000);
        check_value("lrd_cycles", r_as_cnt, 2);
        check_value("lrd_data", r_data, 32'h12345678);
        check_value("lrd_ok", r_ok, 1'b1);

        // BERR and DTACK together on a long read
        run_txn("berr", 24'h000100, 3'd1, 1'b1, 2'd2, 32'h0, 1, 16'hAAAA, 16'h5555);
        check_value("berr_cycles", r_as_cnt, 1);
        check_value("berr_ok", r_ok, 1'b0);

        // VPA cycle
        run_txn("vpa", 24'hBFD000, 3'd5, 1'b1, 2'd1, 32'h0, 2, 16'h00A5, 16'h0);
        check_value("vpa_vma", r_vma_seen, 1'b1);
        check_value("vpa_efall", r_vma_efall, 1'b1);
        check_value("vpa_ok", r_ok, 1'b1);
        check_value("vpa_data", r_data, 32'h000000A5);

        // No response: 16 counted edges in WAIT plus the edge that entered WAIT
        run_txn("tmo", 24'h000200, 3'd1, 1'b1, 2'd1, 32'h0, 3, 16'h0, 16'h0);
        check_value("tmo_ok", r_ok, 1'b0);
        check_value("tmo_rises", r_rises, 17);
        check_value("tmo_as", r_as_at_done, 1'b1);

        // Byte read, even address: upper lane, zero-extended
        run_txn("brd", 24'h000010, 3'd1, 1'b1, 2'd0, 32'h0, 0, 16'hC37E, 16'h0);
        check_value("brd_uds", r_uds_seen, 1'b1);
        check_value("brd_lds", r_lds_seen, 1'b0);
        check_value("brd_data", r_data, 32'h000000C3);
        check_value("brd_ok", r_ok, 1'b1);

        // Reserved size is rejected without bus activity
        @(posedge clk); #1;
        req_size = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_value("rsv_done", done, 1'b1);
        check_value("rsv_ok", term_ok, 1'b0);
        check_value("rsv_bus", {busy, abus_oe, as_n}, 3'b001);
        @(posedge clk); #1;
        check_value("rsv_pulse", done, 1'b0);

        // Reset while in S3
        req_address = 24'h000300; req_rw = 1'b1; req_size = 2'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (!as_n) got = 1'b1;
        end
        check_value("rs3_as_seen", got, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (mc_falling) got = 1'b1;
        end
        check_value("rs3_s3_seen", got, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_value("rs3_as", as_n, 1'b1);
        check_value("rs3_oe", {abus_oe, dbus_oe, ctrl_oe, busy}, 4'b0000);
        reset = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        check_value("rs3_no_done", got, 1'b0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
